// File: rtl/delay_assign_sched.sv
// delay_assign_sched: schedules delayed assignments d = delay (b|c).
// Each request waits in one of DEPTH slots, counts down its own delay and
// then writes the OR result into the shared destination register d.
// Intra-assignment requests (mode 0) capture req_b|req_c at accept time.
// Inter-assignment requests (mode 1) sample live_b|live_c at commit time.
// Optional feature macro: DELAY_SCHED_CANCEL_EN adds the cancel_all input,
// which flushes every slot without committing.

module delay_assign_sched #(
  parameter int DEPTH  = 4,
  parameter int DLY_W  = 8,
  parameter int DATA_W = 1,
  localparam int PW    = $clog2(DEPTH + 1),
  localparam int IW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
`ifdef DELAY_SCHED_CANCEL_EN
  input  logic              cancel_all,
`endif
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_b,
  input  logic [DATA_W-1:0] req_c,
  input  logic [DLY_W-1:0]  req_dly,
  input  logic              req_mode,
  input  logic [DATA_W-1:0] live_b,
  input  logic [DATA_W-1:0] live_c,
  output logic [DATA_W-1:0] d,
  output logic              d_valid,
  output logic              busy,
  output logic [PW-1:0]     pending
);

  // Per-slot state: occupancy, remaining delay, sampling mode, captured value.
  logic [DEPTH-1:0]  r_valid;
  logic [DLY_W-1:0]  r_cnt  [DEPTH];
  logic [DEPTH-1:0]  r_mode;
  logic [DATA_W-1:0] r_val  [DEPTH];
  logic [PW-1:0]     r_pending;
  logic [DATA_W-1:0] r_d;
  logic              r_dValid;

  logic              w_cancel;
  logic              w_freeFound;
  logic [IW-1:0]     w_freeIdx;
  logic              w_commitFound;
  logic [IW-1:0]     w_commitIdx;
  logic              w_accept;
  logic              w_commit;
  logic [DATA_W-1:0] w_commitData;

`ifdef DELAY_SCHED_CANCEL_EN
  assign w_cancel = cancel_all;
`else
  assign w_cancel = 1'b0;
`endif

  // Find the lowest free slot and the lowest expired slot from registered state.
  always_comb begin
    w_freeFound   = 1'b0;
    w_freeIdx     = '0;
    w_commitFound = 1'b0;
    w_commitIdx   = '0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      if (!r_valid[i]) begin
        w_freeFound = 1'b1;
        w_freeIdx   = IW'(i);
      end
      if (r_valid[i] && (r_cnt[i] == '0)) begin
        w_commitFound = 1'b1;
        w_commitIdx   = IW'(i);
      end
    end
  end

  // A cancel blocks both the accept and the commit of the same edge; a slot
  // freed by a commit only shows up as free after that edge.
  assign req_ready = w_freeFound & ~w_cancel;
  assign w_accept  = req_valid & req_ready;
  assign w_commit  = w_commitFound & ~w_cancel;

  // Mode 1 takes the live operands as they are in the commit cycle itself.
  assign w_commitData = r_mode[w_commitIdx] ? (live_b | live_c) : r_val[w_commitIdx];

  // Slot bookkeeping, countdown, commit to d and occupancy count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid   <= '0;
      r_mode    <= '0;
      r_pending <= '0;
      r_d       <= '0;
      r_dValid  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        r_cnt[i] <= '0;
        r_val[i] <= '0;
      end
    end else if (w_cancel) begin
      r_valid   <= '0;
      r_pending <= '0;
      r_dValid  <= 1'b0;
    end else begin
      r_dValid <= w_commit;
      for (int i = 0; i < DEPTH; i++) begin
        if (r_valid[i] && (r_cnt[i] != '0)) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
      if (w_commit) begin
        r_valid[w_commitIdx] <= 1'b0;
        r_d                  <= w_commitData;
      end
      if (w_accept) begin
        r_valid[w_freeIdx] <= 1'b1;
        r_cnt[w_freeIdx]   <= req_dly;
        r_mode[w_freeIdx]  <= req_mode;
        r_val[w_freeIdx]   <= req_b | req_c;
      end
      r_pending <= r_pending + PW'(w_accept) - PW'(w_commit);
    end
  end

  assign d       = r_d;
  assign d_valid = r_dValid;
  assign busy    = |r_valid;
  assign pending = r_pending;

endmodule

// File: tb/tb_delay_assign_sched.sv
// tb_delay_assign_sched: directed vectors plus hand-written multi-cycle
// sequences for delay_assign_sched with DEPTH=4, DLY_W=8, DATA_W=1.

module tb_delay_assign_sched;

  logic       clk;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_b;
  logic       req_c;
  logic [7:0] req_dly;
  logic       req_mode;
  logic       live_b;
  logic       live_c;
  logic       d;
  logic       d_valid;
  logic       busy;
  logic [2:0] pending;
`ifdef DELAY_SCHED_CANCEL_EN
  logic       cancel_all;
`endif

  int nCompared;
  int nMismatched;

  delay_assign_sched #(.DEPTH(4), .DLY_W(8), .DATA_W(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef DELAY_SCHED_CANCEL_EN
    .cancel_all(cancel_all),
`endif
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_b     (req_b),
    .req_c     (req_c),
    .req_dly   (req_dly),
    .req_mode  (req_mode),
    .live_b    (live_b),
    .live_c    (live_c),
    .d         (d),
    .d_valid   (d_valid),
    .busy      (busy),
    .pending   (pending)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic       b;
    logic       c;
    logic [7:0] dly;
    logic       liveB0;
    logic       liveC;
    logic       liveB1;
    logic       expD;
    int         expLat;
  } vec_t;

  vec_t vecs [7];

  // Step one rising edge and settle 1 ns past it
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v, input logic b, input logic c,
                               input logic [7:0] dly, input logic mode);
    req_valid = v;
    req_b     = b;
    req_c     = c;
    req_dly   = dly;
    req_mode  = mode;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Ticks until d_valid is seen (bounded); returns number of ticks taken
  task automatic waitCommit(input int limit, input logic liveLater, output int lat);
    lat = 0;
    while (!d_valid && lat < limit) begin
      tick();
      lat++;
      if (lat == 10) live_b = liveLater;
    end
  endtask

  task automatic countPulses(input int n, output int pulses);
    pulses = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (d_valid) pulses++;
    end
  endtask

  initial begin
    int lat;
    int pulses;
    nCompared   = 0;
    nMismatched = 0;

    //           mode b  c  dly   lb0 lc  lb1 expD lat
    vecs[0] = '{1'b0, 1'b1, 1'b0, 8'd24,  1'b1, 1'b0, 1'b0, 1'b1, 25};
    vecs[1] = '{1'b1, 1'b1, 1'b0, 8'd24,  1'b1, 1'b0, 1'b0, 1'b0, 25};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 8'd0,   1'b0, 1'b0, 1'b0, 1'b1, 1};
    vecs[3] = '{1'b1, 1'b0, 1'b0, 8'd3,   1'b0, 1'b1, 1'b0, 1'b1, 4};
    vecs[4] = '{1'b0, 1'b0, 1'b0, 8'd2,   1'b1, 1'b1, 1'b1, 1'b0, 3};
    vecs[5] = '{1'b1, 1'b1, 1'b1, 8'd15,  1'b0, 1'b0, 1'b1, 1'b1, 16};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 8'd255, 1'b0, 1'b0, 1'b0, 1'b1, 256};

    rst_n  = 1'b0;
    live_b = 1'b0;
    live_c = 1'b0;
`ifdef DELAY_SCHED_CANCEL_EN
    cancel_all = 1'b0;
`endif
    applyStimulus(1'b0, 1'b0, 1'b0, 8'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    checkOutput("reset_d", 32'(d), 0);
    checkOutput("reset_d_valid", 32'(d_valid), 0);
    checkOutput("reset_busy", 32'(busy), 0);
    checkOutput("reset_pending", 32'(pending), 0);
    checkOutput("reset_req_ready", 32'(req_ready), 1);

    // Single requests: latency and sampling mode
    for (int i = 0; i < 7; i++) begin
      live_b = vecs[i].liveB0;
      live_c = vecs[i].liveC;
      applyStimulus(1'b1, vecs[i].b, vecs[i].c, vecs[i].dly, vecs[i].mode);
      tick();
      req_valid = 1'b0;
      checkOutput($sformatf("vec%0d_pending_after_accept", i), 32'(pending), 1);
      waitCommit(300, vecs[i].liveB1, lat);
      checkOutput($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].expLat));
      checkOutput($sformatf("vec%0d_d", i), 32'(d), 32'(vecs[i].expD));
      checkOutput($sformatf("vec%0d_pending_after_commit", i), 32'(pending), 0);
      tick();
      checkOutput($sformatf("vec%0d_pulse_width", i), 32'(d_valid), 0);
    end

    // Collision: both slots expire on the same edge, slot 0 wins
    live_b = 1'b0;
    live_c = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd5, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd4, 1'b0);
    tick();
    req_valid = 1'b0;
    checkOutput("coll_pending2", 32'(pending), 2);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("coll_no_early_commit", 32'(d_valid), 0);
    tick();
    checkOutput("coll_first_valid", 32'(d_valid), 1);
    checkOutput("coll_first_d", 32'(d), 1);
    checkOutput("coll_first_pending", 32'(pending), 1);
    tick();
    checkOutput("coll_second_valid", 32'(d_valid), 1);
    checkOutput("coll_second_d", 32'(d), 0);
    checkOutput("coll_second_pending", 32'(pending), 0);

    // Full: five held requests, fifth waits for the first free slot
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd10, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    checkOutput("full_ready", 32'(req_ready), 0);
    checkOutput("full_pending", 32'(pending), 4);
    req_b = 1'b0;
    waitCommit(50, 1'b0, lat);
    checkOutput("full_first_commit_lat", 32'(lat), 8);
    checkOutput("full_pending_after_first", 32'(pending), 3);
    checkOutput("full_ready_after_first", 32'(req_ready), 1);
    tick();
    req_valid = 1'b0;
    checkOutput("full_accept_and_commit_pending", 32'(pending), 3);
    pulses = d_valid ? 1 : 0;
    begin
      int more;
      countPulses(20, more);
      pulses += more;
    end
    checkOutput("full_remaining_commits", 32'(pulses), 4);
    checkOutput("full_last_d", 32'(d), 0);
    checkOutput("full_drained_busy", 32'(busy), 0);

    // Reset in the middle of three outstanding requests
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    req_valid = 1'b0;
    tick();
    checkOutput("prereset_d", 32'(d), 1);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd20, 1'b1);
    for (int k = 0; k < 3; k++) tick();
    req_valid = 1'b0;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    checkOutput("midreset_d", 32'(d), 0);
    checkOutput("midreset_pending", 32'(pending), 0);
    checkOutput("midreset_busy", 32'(busy), 0);
    countPulses(30, pulses);
    checkOutput("midreset_no_commits", 32'(pulses), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    tick();
    req_valid = 1'b0;
    waitCommit(10, 1'b0, lat);
    checkOutput("postreset_latency", 32'(lat), 1);
    checkOutput("postreset_d", 32'(d), 1);

`ifdef DELAY_SCHED_CANCEL_EN
    // Cancel with a concurrent request: nothing accepted, nothing committed
    tick();
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd20, 1'b0);
    tick();
    tick();
    checkOutput("cancel_pre_pending", 32'(pending), 2);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    cancel_all = 1'b1;
    #1;
    checkOutput("cancel_ready", 32'(req_ready), 0);
    tick();
    cancel_all = 1'b0;
    req_valid  = 1'b0;
    checkOutput("cancel_pending", 32'(pending), 0);
    checkOutput("cancel_d_held", 32'(d), 1);
    checkOutput("cancel_d_valid", 32'(d_valid), 0);
    countPulses(25, pulses);
    checkOutput("cancel_no_commits", 32'(pulses), 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
